integrator_threshold_detector: RTL and testbench
================================================

Name: integrator_threshold_detector

Overview:
Downstream stage of the integrator core. Watches the signed accumulator output every enabled cycle and applies a two-threshold hysteresis comparator with a programmable dwell qualifier. Each qualified crossing becomes a timestamped event, held in a single-entry valid/ready output register for the event consumer (host interface / trigger logic). Overrun is flagged when an event arrives while the register is still full.

Parameters:
ACC_W, 16, width of signed accumulator input and thresholds
DWELL_W, 8, width of dwell qualifier count
TS_W, 16, width of free-running timestamp counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
enable  input  1  stage enable; gates comparator FSM and timestamp counter
acc_in  input  ACC_W  signed accumulator value, sampled each enabled cycle
thr_hi  input  ACC_W  signed upper threshold (rising crossing)
thr_lo  input  ACC_W  signed lower threshold (falling crossing)
dwell_cycles  input  DWELL_W  consecutive cycles required beyond threshold; 0 treated as 1
level_out  output  1  current hysteresis level (1 = HIGH side)
evt_valid  output  1  event register holds an event
evt_ready  input  1  consumer accepts event when evt_valid=1
evt_dir  output  1  1 = rising crossing of thr_hi, 0 = falling crossing of thr_lo
evt_value  output  ACC_W  acc_in on the qualifying cycle
evt_timestamp  output  TS_W  timestamp counter on the qualifying cycle
evt_overrun  output  1  sticky: an event was dropped
clr_overrun  input  1  clears evt_overrun

Behaviour:
- One clock domain (clk); reset is asynchronous and active-high on rst. Reset: FSM=LOW, dwell count=0, timestamp=0, level_out=0, evt_valid=0, evt_dir=0, evt_value=0, evt_timestamp=0, evt_overrun=0. Reset mid-operation discards any pending event and partial dwell.
- Timestamp: increments by 1 every clk with enable=1; wraps 2^TS_W-1 -> 0; holds when enable=0.
- Comparisons strictly signed: above = acc_in > thr_hi; below = acc_in < thr_lo. Equality does not qualify. No checking of thr_lo > thr_hi; comparisons apply as written.
- Effective dwell D = max(dwell_cycles,1). Qualifying cycle counted as 1.
- FSM (advances only when enable=1; holds all state when enable=0):
  LOW: above & D==1 -> HIGH, raise event(dir=1); above & D>1 -> ARM_HI, cnt=1; else stay.
  ARM_HI: above & cnt+1==D -> HIGH, event(dir=1), cnt=0; above -> cnt++; not above -> LOW, cnt=0.
  HIGH: below & D==1 -> LOW, event(dir=0); below & D>1 -> ARM_LO, cnt=1; else stay.
  ARM_LO: mirror of ARM_HI with below/dir=0, returning to HIGH on abort.
- dwell_cycles change mid-arm: compared against live value; if cnt+1 > D on a qualifying cycle, treat as reached (event fires).
- level_out = 1 in HIGH and ARM_LO, 0 in LOW and ARM_HI; registered, changes the cycle after the qualifying sample.
- Event latency: evt_valid, evt_dir, evt_value, evt_timestamp update on the clk edge ending the qualifying cycle (visible 1 cycle after acc_in sample).
- Handshake: transfer when evt_valid & evt_ready; evt_valid drops next cycle unless a new event loads. Outputs stable while evt_valid=1 & !evt_ready.
- Simultaneous new event and transfer: new event loads, evt_valid stays 1 (no bubble).
- New event while evt_valid=1 & !evt_ready: new event dropped, register unchanged, evt_overrun<=1. FSM still transitions (level_out follows).
- clr_overrun clears evt_overrun; set in same cycle wins.
- evt_ready and clr_overrun honoured even when enable=0.

Test Plan:
- Reset/idle: rst pulse, enable=1, acc_in=0, thr_hi=100, thr_lo=-100 -> all outputs 0, timestamp counts 0,1,2...; assert rst mid-count -> timestamp and FSM return to 0/LOW immediately.
- Dwell qualify: D=3, evt_ready=1, acc_in=101 for 3 cycles starting at ts=10 -> one event dir=1, value=101, timestamp=12, level_out=1; acc_in=101,101,50 -> no event, FSM back to LOW.
- Hysteresis/equality: in HIGH, acc_in=-100 for 10 cycles -> no event; acc_in=-101 with D=0 -> event dir=0 next cycle, level_out=0; acc_in=100 in LOW -> no event.
- Back-pressure/overrun: evt_ready=0, D=1, drive rising then falling crossing -> first event held unchanged, second dropped, evt_overrun=1, level_out=0; clr_overrun pulse coincident with third dropped event -> evt_overrun stays 1.
- Simultaneous accept+load: evt_valid=1, evt_ready=1 same cycle as new qualifying sample -> evt_valid stays 1, fields show new event, no overrun.
- Enable gating: enable=0 during ARM_HI with cnt=2 (D=4), acc_in toggled freely -> cnt, FSM, timestamp frozen; re-enable with acc_in above for 2 cycles -> event fires on second cycle; pending event drains via evt_ready while enable=0.

Source files
------------

// File: rtl/integrator_threshold_detector.sv
// rtl/integrator_threshold_detector.sv - hysteresis threshold detector with dwell qualifier and timestamped event register
module integrator_threshold_detector #(
  parameter int ACC_W   = 16,
  parameter int DWELL_W = 8,
  parameter int TS_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [ACC_W-1:0]   acc_in,
  input  logic [ACC_W-1:0]   thr_hi,
  input  logic [ACC_W-1:0]   thr_lo,
  input  logic [DWELL_W-1:0] dwell_cycles,
  output logic               level_out,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic               evt_dir,
  output logic [ACC_W-1:0]   evt_value,
  output logic [TS_W-1:0]    evt_timestamp,
  output logic               evt_overrun,
  input  logic               clr_overrun
);

  typedef enum logic [1:0] {
    S_LOW    = 2'd0,
    S_ARM_HI = 2'd1,
    S_HIGH   = 2'd2,
    S_ARM_LO = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic               level_q, level_d;

  logic               evt_valid_q, evt_valid_d;
  logic               evt_dir_q, evt_dir_d;
  logic [ACC_W-1:0]   evt_value_q, evt_value_d;
  logic [TS_W-1:0]    evt_ts_q, evt_ts_d;
  logic               overrun_q, overrun_d;

  // Comparator and dwell helpers
  logic               above;
  logic               below;
  logic [DWELL_W-1:0] dwell_eff;
  logic               dwell_is_one;
  logic [DWELL_W:0]   cnt_inc;
  logic               dwell_reached;
  logic               fire;
  logic               fire_dir;
  logic               load_evt;
  logic               drop_evt;
  logic               xfer;

  assign above        = $signed(acc_in) > $signed(thr_hi);
  assign below        = $signed(acc_in) < $signed(thr_lo);
  assign dwell_eff    = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
  assign dwell_is_one = (dwell_eff == DWELL_W'(1));
  // cnt+1 is formed one bit wider so a live dwell lowered below cnt still counts as reached
  assign cnt_inc       = {1'b0, cnt_q} + {{DWELL_W{1'b0}}, 1'b1};
  assign dwell_reached = (cnt_inc >= {1'b0, dwell_eff});

  // Hysteresis FSM next-state: arm on the first sample beyond threshold, fire once the dwell is met
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fire     = 1'b0;
    fire_dir = 1'b0;
    if (enable) begin
      case (state_q)
        S_LOW: begin
          if (above) begin
            if (dwell_is_one) begin
              state_d  = S_HIGH;
              fire     = 1'b1;
              fire_dir = 1'b1;
            end else begin
              state_d = S_ARM_HI;
              cnt_d   = DWELL_W'(1);
            end
          end
        end
        S_ARM_HI: begin
          if (above) begin
            if (dwell_reached) begin
              state_d  = S_HIGH;
              cnt_d    = '0;
              fire     = 1'b1;
              fire_dir = 1'b1;
            end else begin
              cnt_d = cnt_inc[DWELL_W-1:0];
            end
          end else begin
            state_d = S_LOW;
            cnt_d   = '0;
          end
        end
        S_HIGH: begin
          if (below) begin
            if (dwell_is_one) begin
              state_d  = S_LOW;
              fire     = 1'b1;
              fire_dir = 1'b0;
            end else begin
              state_d = S_ARM_LO;
              cnt_d   = DWELL_W'(1);
            end
          end
        end
        S_ARM_LO: begin
          if (below) begin
            if (dwell_reached) begin
              state_d  = S_LOW;
              cnt_d    = '0;
              fire     = 1'b1;
              fire_dir = 1'b0;
            end else begin
              cnt_d = cnt_inc[DWELL_W-1:0];
            end
          end else begin
            state_d = S_HIGH;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = S_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Level follows the side of the hysteresis band the FSM is settling on
  always_comb begin
    level_d = (state_d == S_HIGH) || (state_d == S_ARM_LO);
  end

  // Free-running timestamp, frozen while the stage is disabled
  always_comb begin
    ts_d = ts_q;
    if (enable) begin
      ts_d = ts_q + TS_W'(1);
    end
  end

  // Single-entry event register: a transfer frees the slot in the same cycle a new event may load
  always_comb begin
    xfer        = evt_valid_q & evt_ready;
    load_evt    = fire & (~evt_valid_q | evt_ready);
    drop_evt    = fire & evt_valid_q & ~evt_ready;
    evt_valid_d = evt_valid_q;
    evt_dir_d   = evt_dir_q;
    evt_value_d = evt_value_q;
    evt_ts_d    = evt_ts_q;
    if (load_evt) begin
      evt_valid_d = 1'b1;
      evt_dir_d   = fire_dir;
      evt_value_d = acc_in;
      evt_ts_d    = ts_q;
    end else if (xfer) begin
      evt_valid_d = 1'b0;
    end
  end

  // Sticky overrun: a drop in the same cycle as a clear keeps the flag set
  always_comb begin
    overrun_d = overrun_q;
    if (drop_evt) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end
  end

  // Comparator state, dwell count, level and timestamp registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      ts_q    <= ts_d;
    end
  end

  // Event output register and overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid_q <= 1'b0;
      evt_dir_q   <= 1'b0;
      evt_value_q <= '0;
      evt_ts_q    <= '0;
      overrun_q   <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_dir_q   <= evt_dir_d;
      evt_value_q <= evt_value_d;
      evt_ts_q    <= evt_ts_d;
      overrun_q   <= overrun_d;
    end
  end

  assign level_out     = level_q;
  assign evt_valid     = evt_valid_q;
  assign evt_dir       = evt_dir_q;
  assign evt_value     = evt_value_q;
  assign evt_timestamp = evt_ts_q;
  assign evt_overrun   = overrun_q;

endmodule

// File: tb/tb_integrator_threshold_detector.sv
// tb/tb_integrator_threshold_detector.sv - scoreboard bench for integrator_threshold_detector
module tb_integrator_threshold_detector;

  localparam int ACC_W   = 16;
  localparam int DWELL_W = 8;
  localparam int TS_W    = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic [ACC_W-1:0]   acc_in = '0;
  logic [ACC_W-1:0]   thr_hi = '0;
  logic [ACC_W-1:0]   thr_lo = '0;
  logic [DWELL_W-1:0] dwell_cycles = '0;
  logic               level_out;
  logic               evt_valid;
  logic               evt_ready = 1'b0;
  logic               evt_dir;
  logic [ACC_W-1:0]   evt_value;
  logic [TS_W-1:0]    evt_timestamp;
  logic               evt_overrun;
  logic               clr_overrun = 1'b0;

  integrator_threshold_detector #(
    .ACC_W(ACC_W), .DWELL_W(DWELL_W), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .acc_in(acc_in),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .dwell_cycles(dwell_cycles),
    .level_out(level_out), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_dir(evt_dir), .evt_value(evt_value), .evt_timestamp(evt_timestamp),
    .evt_overrun(evt_overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             dir;
    logic [ACC_W-1:0] value;
    logic [TS_W-1:0]  ts;
  } evt_t;

  evt_t            exp_q[$];
  bit              m_level;
  int              m_run;
  logic [TS_W-1:0] m_ts;
  bit              m_valid;
  bit              m_ovr;
  bit              mon_on = 1'b0;
  int              errors = 0;
  int              checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 1'b0;
    m_run   = 0;
    m_ts    = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    exp_q.delete();
  endtask

  // Reference: a run of D consecutive samples beyond the threshold on the far side flips the level
  always @(posedge clk) begin : model
    int              d;
    bit              beyond;
    bit              fire;
    bit              fdir;
    bit              drop;
    logic [TS_W-1:0] ts_now;
    evt_t            e;
    if (!rst) begin
      fire   = 1'b0;
      fdir   = 1'b0;
      ts_now = m_ts;
      if (enable) begin
        m_ts   = m_ts + 1'b1;
        d      = (dwell_cycles == 0) ? 1 : int'(dwell_cycles);
        beyond = m_level ? ($signed(acc_in) < $signed(thr_lo)) : ($signed(acc_in) > $signed(thr_hi));
        if (beyond) begin
          m_run++;
          if (m_run >= d) begin
            fire    = 1'b1;
            fdir    = !m_level;
            m_level = !m_level;
            m_run   = 0;
          end
        end else begin
          m_run = 0;
        end
      end
      drop = fire && m_valid && !evt_ready;
      if (fire && (!m_valid || evt_ready)) begin
        m_valid = 1'b1;
        e.dir   = fdir;
        e.value = acc_in;
        e.ts    = ts_now;
        exp_q.push_back(e);
      end else if (m_valid && evt_ready) begin
        m_valid = 1'b0;
      end
      if (drop) m_ovr = 1'b1;
      else if (clr_overrun) m_ovr = 1'b0;
    end
  end

  // Monitor: compare flags each cycle and the presented event against the scoreboard head
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      check("evt_valid", {31'b0, evt_valid}, {31'b0, m_valid});
      check("level_out", {31'b0, level_out}, {31'b0, m_level});
      check("evt_overrun", {31'b0, evt_overrun}, {31'b0, m_ovr});
      if (evt_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("evt_unexpected", 32'd1, 32'd0);
        end else begin
          check("evt_dir", {31'b0, evt_dir}, {31'b0, exp_q[0].dir});
          check("evt_value", {16'b0, evt_value}, {16'b0, exp_q[0].value});
          check("evt_timestamp", {16'b0, evt_timestamp}, {16'b0, exp_q[0].ts});
          if (evt_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit en, input int acc, input int dw, input bit rdy, input bit clr);
    enable       = en;
    acc_in       = ACC_W'(acc);
    dwell_cycles = DWELL_W'(dw);
    evt_ready    = rdy;
    clr_overrun  = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic random_phase(input int n);
    int vals[9];
    int acc;
    int dw;
    vals = '{-150, -101, -100, -50, 0, 50, 100, 101, 150};
    acc = 0;
    dw  = 1;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 15) == 0) acc = int'($signed(16'($urandom)));
        else acc = vals[$urandom_range(0, 8)];
      end
      if ($urandom_range(0, 15) == 0) dw = $urandom_range(0, 4);
      cyc($urandom_range(0, 7) != 0, acc, dw, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
  endtask

  initial begin
    model_reset();
    thr_hi = 16'(100);
    thr_lo = 16'(-100);
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", {31'b0, level_out}, 32'd0);
    check("rst_valid", {31'b0, evt_valid}, 32'd0);
    check("rst_dir", {31'b0, evt_dir}, 32'd0);
    check("rst_value", {16'b0, evt_value}, 32'd0);
    check("rst_ts", {16'b0, evt_timestamp}, 32'd0);
    check("rst_overrun", {31'b0, evt_overrun}, 32'd0);
    rst    = 1'b0;
    mon_on = 1'b1;

    // idle, then dwell-3 rising qualify starting at ts=10
    repeat (10) cyc(1, 0, 3, 1, 0);
    repeat (3) cyc(1, 101, 3, 1, 0);
    cyc(1, 0, 3, 1, 0);
    // equality on the low side never qualifies; strict crossing with D=0 does
    repeat (10) cyc(1, -100, 3, 1, 0);
    cyc(1, -101, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 100, 0, 1, 0);
    // aborted arm
    cyc(1, 101, 3, 1, 0);
    cyc(1, 101, 3, 1, 0);
    cyc(1, 50, 3, 1, 0);
    // back-pressure: second and third events dropped, clear coincident with a drop
    cyc(1, 101, 1, 0, 0);
    cyc(1, -101, 1, 0, 0);
    cyc(1, 101, 1, 0, 1);
    cyc(1, 0, 1, 0, 0);
    // simultaneous accept and load
    cyc(1, -101, 1, 1, 0);
    cyc(1, 0, 1, 1, 1);
    // enable gating mid-arm, drain while disabled
    cyc(1, 101, 4, 0, 0);
    cyc(1, 101, 4, 0, 0);
    cyc(0, -300, 4, 0, 0);
    cyc(0, 300, 4, 0, 0);
    cyc(0, 0, 4, 0, 0);
    cyc(1, 101, 4, 0, 0);
    cyc(1, 101, 4, 0, 0);
    cyc(0, 0, 4, 0, 0);
    cyc(0, 0, 4, 1, 0);
    cyc(0, 0, 4, 1, 0);

    random_phase(3000);

    // asynchronous reset mid-operation
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_valid", {31'b0, evt_valid}, 32'd0);
    check("midrst_level", {31'b0, level_out}, 32'd0);
    check("midrst_overrun", {31'b0, evt_overrun}, 32'd0);
    check("midrst_ts", {16'b0, evt_timestamp}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    thr_hi = 16'(20);
    thr_lo = 16'(50);
    random_phase(1500);
    thr_hi = 16'(100);
    thr_lo = 16'(-100);
    random_phase(1500);

    repeat (4) cyc(0, 0, 1, 1, 0);
    check("queue_drained", exp_q.size(), 32'd0);
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
